fetch_align: RTL and testbench
==============================

# fetch_align

Instruction aligner between the instruction-fetch word interface and the branch predictor/decode front end. It takes 4-byte-aligned fetch words, splits them into 16-bit parcels, and reassembles 32-bit instructions that straddle word boundaries. Each cycle it presents at most one raw instruction, with its PC, `pc+2`, `pc+4` and compressed flag, in the form the gshare predictor and decoder consume. It also drops stale words after a redirect.

## Interface
Parameters:
- `RESET_VECTOR`, default `32'h4000_0000`: PC of the first instruction after reset.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. One clock; reset is synchronous and active-high.
- `stall_i` in 1: downstream stall. Holds all outputs and internal state.
- `flush_i` in 1: redirect request.
- `redirect_pc_i` in 32: new PC. Bit 0 is ignored.
- `word_valid_i` in 1: fetch word present.
- `word_addr_i` in 32: byte address of the word. Bits [1:0] are 0.
- `word_i` in 32: fetch data, little-endian parcels.
- `word_ready_o` out 1: word accepted this cycle.
- `fetch_valid_o` out 1: output instruction valid.
- `inst_o` out 32: raw instruction. A compressed instruction is zero-extended from [15:0].
- `is_comp_o` out 1: `inst_o[1:0] != 2'b11`.
- `pc_o`, `pc2_o`, `pc4_o` out 32: PC, PC+2 and PC+4 of `inst_o`.

## Operation
State:
- `exp_pc`: PC of the next instruction.
- Parcel buffer: `buf_q[15:0]`, `buf_vld`, `buf_pc`. The buffer always holds the parcel at `exp_pc` when `buf_vld=1`.

Needed word address: `need_addr = {exp_pc[31:2]+exp_pc[1]&buf_vld, 2'b00}`. The word at `exp_pc` is needed unless a valid buffer covers the first parcel, in which case the following word is needed.

Word acceptance:
- `word_ready_o = !stall_i && !flush_i`.
- A word with `word_addr_i != need_addr` is consumed and discarded (stale after a redirect).

Issue rules, evaluated when not stalled and not flushing. `lo=word_i[15:0]`, `hi=word_i[31:16]`:
- **Buffer valid, buffered parcel compressed:** issue `buf_q` without consuming a word. Clear the buffer. `exp_pc += 2`.
- **Buffer valid, 32-bit, matching word:** issue `{lo, buf_q}`. Buffer `hi` at `exp_pc+4`. `exp_pc += 4`.
- **Buffer empty, `exp_pc[1]=0`, matching word:**
  - `lo` compressed: issue `lo`, buffer `hi` with `buf_pc=exp_pc+2`, `exp_pc += 2`.
  - Otherwise: issue the full word, buffer stays empty, `exp_pc += 4`.
- **Buffer empty, `exp_pc[1]=1`, matching word** (entry at an odd halfword after a redirect):
  - `hi` compressed: issue `hi`, `exp_pc += 2`.
  - Otherwise: buffer `hi`, issue nothing.
- **No matching word and no issuable buffer:** `fetch_valid_o` falls to 0.

Flush:
- Clears the buffer, sets `exp_pc = {redirect_pc_i[31:1], 1'b0}` and clears `fetch_valid_o` the next cycle.
- Flush takes priority over stall and over a simultaneous word.

## Timing
- Outputs are registered. An accepted word produces its instruction on the outputs in the following cycle (1-cycle latency).
- While `stall_i=1` and `flush_i=0`, all outputs and state hold and `word_ready_o=0`.
- Straddling 32-bit instruction: issued in the cycle after its second word is accepted.
- Throughput:
  - One instruction per cycle.
  - Compressed pairs from one word take two cycles, the second issued from the buffer with no word needed.
- Reset values:
  - `fetch_valid_o=0`, `inst_o=0`, `is_comp_o=0`, `word_ready_o=0` during reset.
  - `pc_o=RESET_VECTOR`, `pc2_o=RESET_VECTOR+2`, `pc4_o=RESET_VECTOR+4`.
  - `exp_pc=RESET_VECTOR`, `buf_vld=0`.
- Reset in mid-operation discards the buffer and any partial instruction.
- PC arithmetic is modulo 2^32: `32'hFFFF_FFFE + 4` wraps to `32'h0000_0002`.

## Configuration
- `FETCH_ALIGN_RVC_EN` defined: full behaviour above.
- Undefined:
  - No parcel buffer.
  - Every accepted matching word issues as a 32-bit instruction and `exp_pc += 4`.
  - `is_comp_o` is tied to 0 and `redirect_pc_i[1]` is ignored (forced 0).
  - A word with `word_i[1:0] != 2'b11` still issues unchanged, so decode raises illegal-instruction.

## Structure
- In `tcore_param`:
  - `parcel_t` (16-bit), `RVC_OPC_FULL = 2'b11`.
  - `align_out_t` struct bundling `inst`, `is_comp`, `pc`, `pc2`, `pc4`, `valid`.
- Flat module with no sub-module. The parcel buffer is three registers and does not merit its own block.

## Test plan
- **Reset:** release reset with RESET_VECTOR `0x4000_0000` and word `0x00000013` at `0x4000_0000` → next cycle `fetch_valid_o=1`, `inst_o=0x00000013`, `pc_o=0x4000_0000`, `pc4_o=0x4000_0004`, `is_comp_o=0`.
- **Compressed pair:** word `0x45014501` at `0x4000_0000` → `inst_o=0x00004501` at PC `0x4000_0000`, then the same at PC `0x4000_0002`. The second is issued with `word_valid_i=0`.
- **Straddle:** words `0x00134501` then `0x45010000` → `0x4501` at PC `…0`, then `0x00000013` at PC `…2` with `pc4_o=…6`, then `0x4501` from the buffer at PC `…6`.
- **Redirect:**
  - Stimulus: flush to `0x4000_0102`, one stale word at `0x4000_0008`, then word `0x4501_xxxx` at `0x4000_0100`.
  - Response: the stale word is dropped; `0x4501` issues at PC `0x4000_0102`.
- **Flush under stall:** `stall_i=1` with `flush_i=1` → `fetch_valid_o=0` next cycle and the buffer is empty.
- **Stall hold:** `stall_i=1` for 3 cycles mid-straddle → outputs, `buf_q` and `word_ready_o=0` hold; the sequence resumes unchanged.

Source files
------------

// File: rtl/tcore_param.sv
// Shared front-end types for the fetch aligner.
//   parcel_t     : one 16-bit instruction parcel
//   RVC_OPC_FULL : opcode[1:0] value that marks a 32-bit instruction
//   align_out_t  : aligned instruction as handed to predictor/decode
package tcore_param;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned PARCEL_W = 16;

    typedef logic [PARCEL_W-1:0] parcel_t;

    localparam logic [1:0] RVC_OPC_FULL = 2'b11;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] inst;
        logic            is_comp;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc2;
        logic [XLEN-1:0] pc4;
    } align_out_t;

    // True when the parcel starts a 16-bit (compressed) instruction.
    function automatic logic is_rvc(parcel_t p);
        return p[1:0] != RVC_OPC_FULL;
    endfunction

    // Build a valid output record; PC arithmetic wraps modulo 2^32.
    function automatic align_out_t make_out(logic [XLEN-1:0] inst, logic comp,
                                            logic [XLEN-1:0] pc);
        align_out_t o;
        o.valid   = 1'b1;
        o.inst    = inst;
        o.is_comp = comp;
        o.pc      = pc;
        o.pc2     = pc + XLEN'(2);
        o.pc4     = pc + XLEN'(4);
        return o;
    endfunction

endpackage

// File: rtl/fetch_align.sv
// Instruction aligner: splits 4-byte fetch words into 16-bit parcels and
// reassembles instructions (including 32-bit ones straddling two words),
// issuing at most one per cycle with PC, PC+2, PC+4 and compressed flag.
// Words whose address is not the one currently needed are dropped.
//
// Build option: FETCH_ALIGN_RVC_EN enables compressed support and the
// parcel buffer; without it every matching word issues as a 32-bit inst.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-high reset
//   stall_i                  hold all state and outputs
//   flush_i, redirect_pc_i   redirect to a new PC (wins over stall/word)
//   word_valid_i/addr_i/_i   fetch word interface
//   word_ready_o             word accepted this cycle
//   fetch_valid_o, inst_o, is_comp_o, pc_o, pc2_o, pc4_o  registered output
module fetch_align
    import tcore_param::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h4000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        word_valid_i,
    input  logic [31:0] word_addr_i,
    input  logic [31:0] word_i,
    output logic        word_ready_o,
    output logic        fetch_valid_o,
    output logic [31:0] inst_o,
    output logic        is_comp_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc2_o,
    output logic [31:0] pc4_o
);

    logic [XLEN-1:0] exp_pc_q, exp_pc_d;
    align_out_t      out_q, out_d;
    logic [XLEN-1:0] need_addr;
    logic            word_match;

    // Only bit 0 (and bit 1 without RVC) of the redirect target is dropped.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc_i[1:0];

    assign word_ready_o = !rst_ni && !stall_i && !flush_i;
    assign word_match   = word_valid_i && (word_addr_i == need_addr);

`ifdef FETCH_ALIGN_RVC_EN

    parcel_t         buf_q, buf_d;
    logic            buf_vld_q, buf_vld_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    parcel_t         lo, hi;

    assign lo = word_i[15:0];
    assign hi = word_i[31:16];

    // A buffered upper parcel already covers the first half of exp_pc's word.
    assign need_addr = {exp_pc_q[31:2] + 30'(exp_pc_q[1] & buf_vld_q), 2'b00};

    // Next-state and issue selection.
    always_comb begin
        exp_pc_d  = exp_pc_q;
        out_d     = out_q;
        buf_d     = buf_q;
        buf_vld_d = buf_vld_q;
        buf_pc_d  = buf_pc_q;
        if (flush_i) begin
            out_d.valid = 1'b0;
            buf_vld_d   = 1'b0;
            exp_pc_d    = {redirect_pc_i[31:1], 1'b0};
        end else if (!stall_i) begin
            out_d.valid = 1'b0;
            if (buf_vld_q && is_rvc(buf_q)) begin
                out_d     = make_out({16'h0000, buf_q}, 1'b1, buf_pc_q);
                buf_vld_d = 1'b0;
                exp_pc_d  = exp_pc_q + XLEN'(2);
            end else if (buf_vld_q && word_match) begin
                // Straddling 32-bit instruction completes with the low parcel.
                out_d    = make_out({lo, buf_q}, 1'b0, buf_pc_q);
                buf_d    = hi;
                buf_pc_d = exp_pc_q + XLEN'(4);
                exp_pc_d = exp_pc_q + XLEN'(4);
            end else if (!buf_vld_q && word_match && !exp_pc_q[1]) begin
                if (is_rvc(lo)) begin
                    out_d     = make_out({16'h0000, lo}, 1'b1, exp_pc_q);
                    buf_d     = hi;
                    buf_vld_d = 1'b1;
                    buf_pc_d  = exp_pc_q + XLEN'(2);
                    exp_pc_d  = exp_pc_q + XLEN'(2);
                end else begin
                    out_d    = make_out(word_i, 1'b0, exp_pc_q);
                    exp_pc_d = exp_pc_q + XLEN'(4);
                end
            end else if (!buf_vld_q && word_match) begin
                // Entry at an odd halfword: only the upper parcel is ours.
                if (is_rvc(hi)) begin
                    out_d    = make_out({16'h0000, hi}, 1'b1, exp_pc_q);
                    exp_pc_d = exp_pc_q + XLEN'(2);
                end else begin
                    buf_d     = hi;
                    buf_vld_d = 1'b1;
                    buf_pc_d  = exp_pc_q;
                end
            end
        end
    end

    // Parcel buffer registers.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            buf_q     <= '0;
            buf_vld_q <= 1'b0;
            buf_pc_q  <= RESET_VECTOR;
        end else begin
            buf_q     <= buf_d;
            buf_vld_q <= buf_vld_d;
            buf_pc_q  <= buf_pc_d;
        end
    end

`else

    assign need_addr = {exp_pc_q[31:2], 2'b00};

    // Next-state and issue selection, 32-bit instructions only.
    always_comb begin
        exp_pc_d = exp_pc_q;
        out_d    = out_q;
        if (flush_i) begin
            out_d.valid = 1'b0;
            exp_pc_d    = {redirect_pc_i[31:2], 2'b00};
        end else if (!stall_i) begin
            out_d.valid = 1'b0;
            if (word_match) begin
                out_d    = make_out(word_i, 1'b0, exp_pc_q);
                exp_pc_d = exp_pc_q + XLEN'(4);
            end
        end
    end

`endif

    // Expected PC and registered output record.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            exp_pc_q <= RESET_VECTOR;
            out_q    <= '{valid: 1'b0, inst: '0, is_comp: 1'b0, pc: RESET_VECTOR,
                          pc2: RESET_VECTOR + XLEN'(2), pc4: RESET_VECTOR + XLEN'(4)};
        end else begin
            exp_pc_q <= exp_pc_d;
            out_q    <= out_d;
        end
    end

    assign fetch_valid_o = out_q.valid;
    assign inst_o        = out_q.inst;
    assign is_comp_o     = out_q.is_comp;
    assign pc_o          = out_q.pc;
    assign pc2_o         = out_q.pc2;
    assign pc4_o         = out_q.pc4;

endmodule

// File: tb/tb_fetch_align.sv
// Bench for fetch_align: directed vector table, hand-written reset
// sequences, and a randomized run scored against an instruction-stream model.
module tb_fetch_align;

    localparam logic [31:0] RV = 32'h4000_0000;
`ifdef FETCH_ALIGN_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni, stall_i, flush_i, word_valid_i;
    logic [31:0] redirect_pc_i, word_addr_i, word_i;
    logic        word_ready_o, fetch_valid_o, is_comp_o;
    logic [31:0] inst_o, pc_o, pc2_o, pc4_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    fetch_align #(.RESET_VECTOR(RV)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i), .flush_i(flush_i),
        .redirect_pc_i(redirect_pc_i), .word_valid_i(word_valid_i),
        .word_addr_i(word_addr_i), .word_i(word_i), .word_ready_o(word_ready_o),
        .fetch_valid_o(fetch_valid_o), .inst_o(inst_o), .is_comp_o(is_comp_o),
        .pc_o(pc_o), .pc2_o(pc2_o), .pc4_o(pc4_o)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(string tag, logic v, logic [31:0] inst, logic comp,
                             logic [31:0] pc);
        chk({tag, " valid"}, 32'(fetch_valid_o), 32'(v));
        if (v) begin
            chk({tag, " inst"}, inst_o, inst);
            chk({tag, " is_comp"}, 32'(is_comp_o), 32'(comp));
            chk({tag, " pc"}, pc_o, pc);
            chk({tag, " pc2"}, pc2_o, pc + 32'd2);
            chk({tag, " pc4"}, pc4_o, pc + 32'd4);
        end
    endtask

    // Drive one cycle of inputs (at a negedge), check ready, advance to next negedge.
    task automatic step(logic rst, logic st, logic fl, logic [31:0] rpc,
                        logic wv, logic [31:0] wa, logic [31:0] w);
        rst_ni = rst; stall_i = st; flush_i = fl; redirect_pc_i = rpc;
        word_valid_i = wv; word_addr_i = wa; word_i = w;
        #1;
        chk("word_ready", 32'(word_ready_o), 32'(!rst && !st && !fl));
        @(negedge clk_i);
    endtask

    task automatic check_reset(string tag);
        chk({tag, " valid"}, 32'(fetch_valid_o), 32'd0);
        chk({tag, " inst"}, inst_o, 32'd0);
        chk({tag, " is_comp"}, 32'(is_comp_o), 32'd0);
        chk({tag, " pc"}, pc_o, RV);
        chk({tag, " pc2"}, pc2_o, RV + 32'd2);
        chk({tag, " pc4"}, pc4_o, RV + 32'd4);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        st;
        logic        fl;
        logic [31:0] rpc;
        logic        wv;
        logic [31:0] wa;
        logic [31:0] w;
        logic        ev;
        logic [31:0] ei;
        logic        ec;
        logic [31:0] ep;
    } vec_t;
    vec_t vecs[$];

    function automatic void vw(logic [31:0] wa, logic [31:0] w, logic ev,
                               logic [31:0] ei, logic ec, logic [31:0] ep);
        vecs.push_back('{1'b0, 1'b0, 32'd0, 1'b1, wa, w, ev, ei, ec, ep});
    endfunction
    function automatic void vn(logic ev, logic [31:0] ei, logic ec, logic [31:0] ep);
        vecs.push_back('{1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, ev, ei, ec, ep});
    endfunction
    function automatic void vf(logic st, logic [31:0] rpc);
        vecs.push_back('{st, 1'b1, rpc, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0});
    endfunction
    function automatic void vs(logic [31:0] wa, logic [31:0] w, logic [31:0] ei,
                               logic ec, logic [31:0] ep);
        vecs.push_back('{1'b1, 1'b0, 32'd0, 1'b1, wa, w, 1'b1, ei, ec, ep});
    endfunction

    // ---------------- random-run reference model ----------------
    logic [15:0] mem[logic [31:0]];

    function automatic logic [15:0] parcel(logic [31:0] a);
        logic [15:0] p;
        if (!mem.exists(a)) begin
            p = 16'($urandom);
            if ($urandom_range(1, 0) == 0) p[1:0] = 2'b11;
            else p[1:0] = 2'($urandom_range(2, 0));
            mem[a] = p;
        end
        return mem[a];
    endfunction

    // Instruction that starts at pc, per the stream definition.
    task automatic decode(input logic [31:0] pc, output logic [31:0] inst,
                          output logic comp, output logic [31:0] len);
        logic [15:0] lo;
        lo = parcel(pc);
        if (RVC && lo[1:0] != 2'b11) begin
            inst = {16'h0000, lo}; comp = 1'b1; len = 32'd2;
        end else begin
            inst = {parcel(pc + 32'd2), lo}; comp = 1'b0; len = 32'd4;
        end
    endtask

    initial begin
        logic [31:0] head, faddr, rpc, wa, w, ei, len, last_inst;
        logic        pflush, pstall, fl, st, wv, gate, ec, last_valid;
        logic [15:0] hp;
        int          idle, issued;

        // Reset held for two cycles.
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        check_reset("reset");

        if (RVC) begin
            vw(RV,            32'h0000_0013, 1, 32'h13,   0, RV);
            vw(RV + 32'h4,    32'h4501_4501, 1, 32'h4501, 1, RV + 32'h4);
            vn(                              1, 32'h4501, 1, RV + 32'h6);
            vw(RV + 32'h8,    32'h0013_4501, 1, 32'h4501, 1, RV + 32'h8);
            vw(RV + 32'hC,    32'h4501_0000, 1, 32'h13,   0, RV + 32'hA);
            vn(                              1, 32'h4501, 1, RV + 32'hE);
            vn(                              0, 32'h0,    0, 32'h0);
            vf(0, 32'h4000_0102);
            vw(32'h4000_0008, 32'hDEAD_BEEF, 0, 32'h0,    0, 32'h0);
            vw(32'h4000_0100, 32'h4501_ABCD, 1, 32'h4501, 1, 32'h4000_0102);
            vw(32'h4000_0104, 32'h0013_4501, 1, 32'h4501, 1, 32'h4000_0104);
            for (int i = 0; i < 3; i++) vs(32'h4000_0108, 32'h4501_0000, 32'h4501, 1, 32'h4000_0104);
            vw(32'h4000_0108, 32'h4501_0000, 1, 32'h13,   0, 32'h4000_0106);
            vn(                              1, 32'h4501, 1, 32'h4000_010A);
            vw(32'h4000_010C, 32'h4501_4501, 1, 32'h4501, 1, 32'h4000_010C);
            vf(1, 32'h4000_0200);
            vn(                              0, 32'h0,    0, 32'h0);
            vw(32'h4000_0200, 32'h0000_0013, 1, 32'h13,   0, 32'h4000_0200);
            vf(0, 32'hFFFF_FFFE);
            vw(32'hFFFF_FFFC, 32'h0013_0000, 0, 32'h0,    0, 32'h0);
            vw(32'h0000_0000, 32'h4501_0000, 1, 32'h13,   0, 32'hFFFF_FFFE);
            vn(                              1, 32'h4501, 1, 32'h0000_0002);
        end else begin
            vw(RV,            32'h0000_0013, 1, 32'h13,        0, RV);
            vw(RV + 32'h4,    32'h4501_4501, 1, 32'h4501_4501, 0, RV + 32'h4);
            vn(                              0, 32'h0,         0, 32'h0);
            vf(0, 32'h4000_0102);
            vw(32'h4000_0008, 32'hDEAD_BEEF, 0, 32'h0,         0, 32'h0);
            vw(32'h4000_0100, 32'h4501_ABCD, 1, 32'h4501_ABCD, 0, 32'h4000_0100);
            vw(32'h4000_0104, 32'h0000_0013, 1, 32'h13,        0, 32'h4000_0104);
            for (int i = 0; i < 3; i++) vs(32'h4000_0108, 32'h0000_0093, 32'h13, 0, 32'h4000_0104);
            vw(32'h4000_0108, 32'h0000_0093, 1, 32'h93,        0, 32'h4000_0108);
            vf(1, 32'h4000_0200);
            vn(                              0, 32'h0,         0, 32'h0);
            vw(32'h4000_0200, 32'h0000_0013, 1, 32'h13,        0, 32'h4000_0200);
            vf(0, 32'hFFFF_FFFC);
            vw(32'hFFFF_FFFC, 32'h0000_0013, 1, 32'h13,        0, 32'hFFFF_FFFC);
            vw(32'h0000_0000, 32'h0000_0033, 1, 32'h33,        0, 32'h0000_0000);
        end

        foreach (vecs[i]) begin
            step(1'b0, vecs[i].st, vecs[i].fl, vecs[i].rpc, vecs[i].wv, vecs[i].wa, vecs[i].w);
            check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ei, vecs[i].ec, vecs[i].ep);
        end

        // Randomized run: bench fetches words in order from a lazily filled memory.
        head = 32'd0; faddr = 32'd0; pflush = 1'b0; pstall = 1'b0;
        last_valid = 1'b0; last_inst = 32'd0; idle = 0; issued = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) begin
                if (pflush) begin
                    chk("rnd flush valid", 32'(fetch_valid_o), 32'd0);
                end else if (pstall) begin
                    chk("rnd stall valid", 32'(fetch_valid_o), 32'(last_valid));
                    chk("rnd stall inst", inst_o, last_inst);
                end else if (fetch_valid_o) begin
                    decode(head, ei, ec, len);
                    check_out("rnd", 1'b1, ei, ec, head);
                    head = head + len;
                    issued++;
                    idle = 0;
                end else begin
                    idle++;
                    if (idle > 40) begin
                        chk("rnd watchdog idle", 32'(idle), 32'd0);
                        break;
                    end
                end
            end
            last_valid = fetch_valid_o;
            last_inst  = inst_o;

            fl = (c == 0) || ($urandom_range(29, 0) == 0);
            st = ($urandom_range(3, 0) == 0);
            rpc = 32'h1000_0000 + 32'($urandom_range(2047, 0)) * 32'd2 + 32'($urandom_range(1, 0));

            // Next instruction compressed and already fetched into the buffer: no word wanted.
            hp   = parcel(head);
            gate = RVC && head[1] && (hp[1:0] != 2'b11) && (faddr != {head[31:2], 2'b00});
            wv = 1'b0; wa = 32'd0; w = 32'd0;
            if (!gate && $urandom_range(3, 0) != 0) begin
                wv = 1'b1; wa = faddr; w = {parcel(faddr + 32'd2), parcel(faddr)};
            end else if ($urandom_range(7, 0) == 0) begin
                wv = 1'b1; wa = faddr + 32'h100; w = $urandom;
            end

            if (fl) begin
                head  = RVC ? {rpc[31:1], 1'b0} : {rpc[31:2], 2'b00};
                faddr = {head[31:2], 2'b00};
            end else if (wv && !st && wa == faddr) begin
                faddr = faddr + 32'd4;
            end
            step(1'b0, st, fl, rpc, wv, wa, w);
            pflush = fl;
            pstall = st && !fl;
        end
        chk("rnd progress", 32'(issued >= 300), 32'd1);

        // Reset in mid-operation, then restart at the reset vector.
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, RV, 32'h4501_4501);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, RV, 32'h4501_4501);
        check_reset("midreset");
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, RV, 32'h0000_0013);
        check_out("post reset", 1'b1, 32'h13, 1'b0, RV);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
